parking_gate_controller: RTL
============================

# parking_gate_controller

Parametrised parking-lot occupancy controller with one entry gate and one exit gate. Each gate runs its own request/open/pass handshake with a timeout. Occupancy is committed only when a vehicle is sensed passing a gate, and admission is refused at capacity. It sits between the gate sensors/actuators and the lot status display, and supersedes the fixed 4-bit arrival/departure counter.

## Interface
- CAPACITY, 15: number of parking spaces (≥1).
- CNT_W, $clog2(CAPACITY+1): occupancy counter width.
- OPEN_TIMEOUT, 8: max cycles a gate stays open waiting for a pass (≥1).
- NEAR_FULL, CAPACITY-2: near_full threshold (≤CAPACITY).
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- entry_req  in  1  vehicle waiting at entry gate (level).
- entry_pass  in  1  entry pass sensor (vehicle crossed).
- exit_req  in  1  vehicle waiting at exit gate (level).
- exit_pass  in  1  exit pass sensor.
- entry_gate_open  out  1  entry barrier open.
- exit_gate_open  out  1  exit barrier open.
- entry_denied  out  1  registered pulse: entry refused, lot full.
- exit_denied  out  1  registered pulse: exit refused, lot empty.
- entry_timeout  out  1  one-cycle pulse: entry gate closed without pass.
- exit_timeout  out  1  one-cycle pulse: exit gate closed without pass.
- count  out  CNT_W  committed occupancy.
- full_signal  out  1  count == CAPACITY.
- empty_signal  out  1  count == 0.
- near_full  out  1  count >= NEAR_FULL.

## Operation
- Each gate has its own FSM with two states, IDLE and OPEN.
- IDLE -> OPEN: req high and the gate is admitted.
  - Entry is admitted when count < CAPACITY.
  - Exit is admitted when count > 0.
- IDLE with req high and not admitted: stay in IDLE and pulse denied the next cycle. This repeats every cycle req is sampled high while refused.
- OPEN -> IDLE on pass high: commit. Entry commits +1, exit commits -1.
- OPEN -> IDLE on timer == OPEN_TIMEOUT-1 with pass low: timeout pulse, no count change.
- Pass has priority over timeout in the same cycle.
- Pass inputs are ignored in IDLE.
- req is ignored in OPEN. A gate returns to IDLE for at least one cycle between vehicles.
- Simultaneous entry and exit commit: net zero, so count is unchanged.
- Count never wraps and never leaves 0..CAPACITY.
  - Entry commit at CAPACITY cannot occur, because admission gated it.
  - Exit commit at 0 is likewise impossible. The RTL still saturates as a guard.
- Admission uses the committed count only. An exit pending while the entry is open does not pre-release a space.
- full_signal, empty_signal and near_full are decoded from the count register. They are glitch-free and change in the same cycle as count.

## Timing
- Reset values: count 0, empty_signal 1, full_signal 0, near_full 0 (1 only if NEAR_FULL == 0). Both gates are closed, all pulses are 0, both FSMs are IDLE and timers are 0.
- Admission latency: req sampled high at edge N makes gate_open high from edge N+1.
- Denial latency: denied is high from edge N+1 for one cycle.
- Commit latency: pass sampled high at edge M while OPEN.
  - gate_open goes low and count updates, both visible after edge M.
  - Status flags update in the same cycle as count.
- Timeout: gate_open is high for exactly OPEN_TIMEOUT cycles, then low. The timeout pulse is high for one cycle, coincident with the first closed cycle.
- Reset mid-operation: on the edge reset is sampled high, gates close and count clears. A pass sensed in that cycle is discarded. No timeout or denied pulse is emitted for the aborted transaction.
- No combinational path from any input to any output.

## Structure
- Package parking_pkg holds:
  - gate_state_t enum {GATE_IDLE, GATE_OPEN};
  - localparam function for counter width;
  - commit-encoding constants (COMMIT_NONE, COMMIT_INC, COMMIT_DEC).
- Sub-module parking_gate_fsm, instantiated twice (entry and exit).
  - Inputs: clock, reset, req, pass, admit.
  - Outputs: gate_open, denied, timeout, commit.
  - Parameter: OPEN_TIMEOUT.
- The top level owns the occupancy counter, the admit comparisons, commit merging and flag decode.

## Test plan
- CAPACITY=3, OPEN_TIMEOUT=4. Three entries, each req then pass on the 2nd open cycle -> count 1,2,3; full_signal=1 after the third commit; near_full=1 from count 1.
- Full lot: entry_req held for 3 cycles -> entry_gate_open stays 0; entry_denied high on 3 consecutive cycles; count stays 3.
- Entry req with no pass -> entry_gate_open high exactly 4 cycles; entry_timeout pulses once; count unchanged.
- count=2, entry and exit pass in the same cycle -> count stays 2, both gates close together. Then exit_req at count 0 after two exits -> exit_denied and empty_signal=1.
- Reset asserted while entry gate open and entry_pass high -> count 0, entry_gate_open 0 next cycle, no timeout pulse, empty_signal 1.
- Pass on the final open cycle (timer 3) -> commit happens and entry_timeout stays 0.

Source files
------------

// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module   : parking_pkg
// Brief    : Shared types and constants for the parking gate controller.
// Revision : 1.0
// ============================================================================

package parking_pkg;

    typedef enum logic [0:0] {
        GATE_IDLE = 1'b0,
        GATE_OPEN = 1'b1
    } gate_state_t;

    // Entry and exit commits are OR-merged, so both together read as 2'b11.
    typedef logic [1:0] commit_t;
    localparam commit_t COMMIT_NONE = 2'b00;
    localparam commit_t COMMIT_INC  = 2'b01;
    localparam commit_t COMMIT_DEC  = 2'b10;

    function automatic int cnt_width(input int capacity);
        return (capacity < 1) ? 1 : $clog2(capacity + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/parking_gate_fsm.sv
`default_nettype none
// ============================================================================
// Module   : parking_gate_fsm
// Brief    : One barrier's request/open/pass handshake with an open timeout.
// Revision : 1.0
// ============================================================================

module parking_gate_fsm
    import parking_pkg::*;
#(
    parameter int OPEN_TIMEOUT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic req,
    input  logic pass,
    input  logic admit,
    output logic gate_open,
    output logic denied,
    output logic timeout,
    output logic commit
);

    localparam int TMR_W = (OPEN_TIMEOUT > 1) ? $clog2(OPEN_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] c_timer_last = TMR_W'(OPEN_TIMEOUT - 1);

    gate_state_t      r_state;
    gate_state_t      w_state_next;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_next;
    logic             r_denied;
    logic             w_denied_next;
    logic             r_timeout;
    logic             w_timeout_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= GATE_IDLE;
            r_timer   <= '0;
            r_denied  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_denied  <= w_denied_next;
            r_timeout <= w_timeout_next;
        end
    end

    // commit is combinational so the counter updates on the same edge that samples pass.
    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer;
        w_denied_next  = 1'b0;
        w_timeout_next = 1'b0;
        commit         = 1'b0;
        case (r_state)
            GATE_IDLE: begin
                w_timer_next = '0;
                if (req) begin
                    if (admit) begin
                        w_state_next = GATE_OPEN;
                    end else begin
                        w_denied_next = 1'b1;
                    end
                end
            end
            GATE_OPEN: begin
                if (pass) begin
                    commit       = 1'b1;
                    w_state_next = GATE_IDLE;
                    w_timer_next = '0;
                end else if (r_timer == c_timer_last) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = GATE_IDLE;
                    w_timer_next   = '0;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_next = GATE_IDLE;
                w_timer_next = '0;
            end
        endcase
    end

    assign gate_open = (r_state == GATE_OPEN);
    assign denied    = r_denied;
    assign timeout   = r_timeout;

endmodule

`default_nettype wire

// File: rtl/parking_gate_controller.sv
`default_nettype none
// ============================================================================
// Module   : parking_gate_controller
// Brief    : Lot occupancy counter driven by independent entry/exit gate FSMs.
// Revision : 1.0
// ============================================================================

module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int CAPACITY     = 15,
    parameter int CNT_W        = cnt_width(CAPACITY),
    parameter int OPEN_TIMEOUT = 8,
    parameter int NEAR_FULL    = CAPACITY - 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             entry_pass,
    input  logic             exit_req,
    input  logic             exit_pass,
    output logic             entry_gate_open,
    output logic             exit_gate_open,
    output logic             entry_denied,
    output logic             exit_denied,
    output logic             entry_timeout,
    output logic             exit_timeout,
    output logic [CNT_W-1:0] count,
    output logic             full_signal,
    output logic             empty_signal,
    output logic             near_full
);

    localparam logic [CNT_W-1:0] c_capacity    = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] c_near_full   = CNT_W'(NEAR_FULL);
    localparam logic             c_near_always = (NEAR_FULL <= 0);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_full;
    logic             r_empty;
    logic             r_near;
    logic             w_entry_admit;
    logic             w_exit_admit;
    logic             w_entry_commit;
    logic             w_exit_commit;
    commit_t          w_commit;

    // Admission looks only at committed occupancy; a pending exit frees nothing.
    assign w_entry_admit = (r_count < c_capacity);
    assign w_exit_admit  = (r_count != '0);

    parking_gate_fsm #(
        .OPEN_TIMEOUT (OPEN_TIMEOUT)
    ) u_entry_gate (
        .clock     (clock),
        .reset     (reset),
        .req       (entry_req),
        .pass      (entry_pass),
        .admit     (w_entry_admit),
        .gate_open (entry_gate_open),
        .denied    (entry_denied),
        .timeout   (entry_timeout),
        .commit    (w_entry_commit)
    );

    parking_gate_fsm #(
        .OPEN_TIMEOUT (OPEN_TIMEOUT)
    ) u_exit_gate (
        .clock     (clock),
        .reset     (reset),
        .req       (exit_req),
        .pass      (exit_pass),
        .admit     (w_exit_admit),
        .gate_open (exit_gate_open),
        .denied    (exit_denied),
        .timeout   (exit_timeout),
        .commit    (w_exit_commit)
    );

    // Simultaneous commits merge to INC|DEC and fall through to "hold".
    always_comb begin
        w_commit = COMMIT_NONE;
        if (w_entry_commit) begin
            w_commit = w_commit | COMMIT_INC;
        end
        if (w_exit_commit) begin
            w_commit = w_commit | COMMIT_DEC;
        end
        w_count_next = r_count;
        case (w_commit)
            COMMIT_INC: begin
                if (r_count < c_capacity) begin
                    w_count_next = r_count + 1'b1;
                end
            end
            COMMIT_DEC: begin
                if (r_count != '0) begin
                    w_count_next = r_count - 1'b1;
                end
            end
            default: w_count_next = r_count;
        endcase
    end

    // Flags are registered from the next count so they move with count, glitch-free.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_near  <= c_near_always;
        end else begin
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_capacity);
            r_empty <= (w_count_next == '0);
            r_near  <= c_near_always || (w_count_next >= c_near_full);
        end
    end

    assign count        = r_count;
    assign full_signal  = r_full;
    assign empty_signal = r_empty;
    assign near_full    = r_near;

endmodule

`default_nettype wire
